adc_decimator: RTL

ADC_DECIMATOR -- requirements
Module: adc_decimator

---
 rtl/adc_dsp_pkg.sv | 19 +
 rtl/adc_decimator_if.sv | 25 ++
 rtl/adc_decimator.sv | 121 ++++++++++++
 3 files changed

// File: rtl/adc_dsp_pkg.sv
// Shared definitions for the ADC decimation blocks: state encoding, default
// parameters and counter sizing helper.
package adc_dsp_pkg;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_ACCUM  = 1'b1
    } state_t;

    localparam int unsigned DEF_BITS   = 8;
    localparam int unsigned DEF_LOG2_N = 2;
    localparam int unsigned DEF_SETTLE = 3;

    // Counter width able to hold 0..limit-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/adc_decimator_if.sv
// Sample/result bundle around adc_decimator: producer drives codes and the
// consumer ready, the decimator returns averaged codes and status flags.
interface adc_decimator_if
    import adc_dsp_pkg::*;
#(
    parameter int unsigned BITS = DEF_BITS
);
    logic [0:BITS-1] in_code;
    logic            in_valid;
    logic [0:BITS-1] out_code;
    logic            out_valid;
    logic            out_ready;
    logic            clip;
    logic            overrun;

    modport master (
        output in_code, in_valid, out_ready,
        input  out_code, out_valid, clip, overrun
    );

    modport slave (
        input  in_code, in_valid, out_ready,
        output out_code, out_valid, clip, overrun
    );
endinterface

// File: rtl/adc_decimator.sv
// Boxcar decimator: discards SETTLE samples after reset, then averages each
// group of 2**LOG2_N accepted ADC codes into one truncated output code.
module adc_decimator
    import adc_dsp_pkg::*;
#(
    parameter int unsigned BITS   = DEF_BITS,
    parameter int unsigned LOG2_N = DEF_LOG2_N,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [0:BITS-1] in_code,
    input  logic            in_valid,
    output logic [0:BITS-1] out_code,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            clip,
    output logic            overrun
);

    localparam int unsigned N           = 2 ** LOG2_N;
    localparam int unsigned ACC_W       = BITS + LOG2_N;
    localparam int unsigned SCNT_W      = cnt_width(SETTLE);
    localparam int unsigned NCNT_W      = cnt_width(N);
    localparam int unsigned SETTLE_LAST = (SETTLE == 0) ? 0 : SETTLE - 1;
    localparam bit          NO_SETTLE   = (SETTLE == 0);

    state_t              state;
    state_t              state_next;
    logic [SCNT_W-1:0]   scnt;
    logic [NCNT_W-1:0]   ncnt;
    logic [ACC_W-1:0]    acc;

    logic                accept_c;
    logic                last_c;
    logic                load_c;
    logic [ACC_W-1:0]    sum_c;
    logic [0:BITS-1]     result_c;

    // With no settle period the first post-reset sample is already averaged.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = (ncnt == NCNT_W'(N - 1));
        sum_c      = acc + ACC_W'(in_code);
        result_c   = BITS'(sum_c >> LOG2_N);

        case (state)
            ST_SETTLE: begin
                if (NO_SETTLE) begin
                    state_next = ST_ACCUM;
                    accept_c   = in_valid;
                end else if (in_valid && scnt == SCNT_W'(SETTLE_LAST)) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                accept_c = in_valid;
            end
            default: begin
                state_next = ST_SETTLE;
            end
        endcase

        load_c = accept_c && last_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SETTLE;
        end else begin
            state <= state_next;
        end
    end

    // Settle counter, sample counter and running sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt <= '0;
            ncnt <= '0;
            acc  <= '0;
        end else begin
            if (state == ST_SETTLE && in_valid && !NO_SETTLE) begin
                scnt <= scnt + SCNT_W'(1);
            end
            if (accept_c) begin
                if (last_c) begin
                    ncnt <= '0;
                    acc  <= '0;
                end else begin
                    ncnt <= ncnt + NCNT_W'(1);
                    acc  <= sum_c;
                end
            end
        end
    end

    // Result register with consume/overwrite handling and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_code  <= '0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load_c) begin
                out_code  <= result_c;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept_c && in_code == '1) begin
                clip <= 1'b1;
            end
        end
    end

endmodule
